// File: rtl/matrix_row_sequencer.sv
// Row sequencer for the packed element-wise matrix ALU: streams A/B operand rows
// out of memory, holds them steady for the ALU, writes each result row back and tracks overflow.
module matrix_row_sequencer #(
  parameter int A_BASE = 0,
  parameter int B_BASE = 5,
  parameter int C_BASE = 10,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [39:0]       rd_data,
  output logic [39:0]       op_m1,
  output logic [39:0]       op_m2,
  input  logic [39:0]       alu_out,
  input  logic              alu_ovf,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [39:0]       wr_data,
  output logic [4:0]        ovf_row,
  output logic              ovf_flag
);

  localparam logic [2:0]        LAST_ROW = 3'd4;
  localparam logic [ADDR_W-1:0] A_OFS    = ADDR_W'(A_BASE);
  localparam logic [ADDR_W-1:0] B_OFS    = ADDR_W'(B_BASE);
  localparam logic [ADDR_W-1:0] C_OFS    = ADDR_W'(C_BASE);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_A, S_RD_B, S_CAP_B, S_EXEC, S_WR, S_DONE
  } state_t;

  state_t            state_q;
  logic [2:0]        row_q;
  logic              busy_q, done_q, rd_en_q, wr_en_q;
  logic [ADDR_W-1:0] rd_addr_q, wr_addr_q;
  logic [39:0]       op_m1_q, op_m2_q, wr_data_q;
  logic [4:0]        ovf_row_q;

  logic [2:0]        row_inc_d;
  logic [ADDR_W-1:0] a_next_addr_d, b_addr_d, c_addr_d;

  // Address sums wrap naturally at ADDR_W bits; overlapping regions are the caller's business.
  assign row_inc_d     = row_q + 3'd1;
  assign a_next_addr_d = A_OFS + ADDR_W'(row_inc_d);
  assign b_addr_d      = B_OFS + ADDR_W'(row_q);
  assign c_addr_d      = C_OFS + ADDR_W'(row_q);

  // Strobes and addresses are registered one state ahead so they are valid for
  // the whole cycle of the state they belong to and read zero otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      row_q     <= 3'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      op_m1_q   <= '0;
      op_m2_q   <= '0;
      wr_data_q <= '0;
      ovf_row_q <= '0;
    end else begin
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      done_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            row_q     <= 3'd0;
            ovf_row_q <= '0;
            op_m1_q   <= '0;
            op_m2_q   <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b1;
            rd_en_q   <= 1'b1;
            rd_addr_q <= A_OFS;
            state_q   <= S_RD_A;
          end
        end
        S_RD_A: begin
          rd_en_q   <= 1'b1;
          rd_addr_q <= b_addr_d;
          state_q   <= S_RD_B;
        end
        S_RD_B: begin
          op_m1_q <= rd_data;
          state_q <= S_CAP_B;
        end
        S_CAP_B: begin
          op_m2_q <= rd_data;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          // Operands have been stable a full cycle here, so alu_out is settled.
          wr_data_q        <= alu_out;
          ovf_row_q[row_q] <= ovf_row_q[row_q] | alu_ovf;
          wr_en_q          <= 1'b1;
          wr_addr_q        <= c_addr_d;
          state_q          <= S_WR;
        end
        S_WR: begin
          if (row_q == LAST_ROW) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            row_q     <= row_inc_d;
            rd_en_q   <= 1'b1;
            rd_addr_q <= a_next_addr_d;
            state_q   <= S_RD_A;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rd_en    = rd_en_q;
  assign rd_addr  = rd_addr_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign op_m1    = op_m1_q;
  assign op_m2    = op_m2_q;
  assign wr_data  = wr_data_q;
  assign ovf_row  = ovf_row_q;
  assign ovf_flag = |ovf_row_q;

endmodule

// File: tb/tb_matrix_row_sequencer.sv
// Bench for matrix_row_sequencer: registered-read operand memory, lane-wise
// subtract ALU, table of row vectors per run and a write-back scoreboard.
module tb_matrix_row_sequencer;

  localparam int A_BASE = 0;
  localparam int B_BASE = 5;
  localparam int C_BASE = 10;
  localparam int AW     = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, rd_en, wr_en, alu_ovf, ovf_flag;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [39:0]   rd_data, op_m1, op_m2, alu_out, wr_data;
  logic [4:0]    ovf_row;

  matrix_row_sequencer #(
    .A_BASE(A_BASE), .B_BASE(B_BASE), .C_BASE(C_BASE), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .op_m1(op_m1), .op_m2(op_m2), .alu_out(alu_out), .alu_ovf(alu_ovf),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .ovf_row(ovf_row), .ovf_flag(ovf_flag)
  );

  always #5 clk = ~clk;

  // Operand memory: one-cycle registered read, synchronous write, bulk preload.
  logic [39:0] mem   [16];
  logic [39:0] stage [16];
  logic        load = 1'b0;

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 16; i++) mem[i] <= stage[i];
    end else begin
      if (rd_en) rd_data <= mem[rd_addr];
      if (wr_en) mem[wr_addr] <= wr_data;
    end
  end

  // Environment ALU: five signed 8-bit lanes, m1 - m2, wrap-around with overflow flag.
  function automatic logic [40:0] sub40(input logic [39:0] a, input logic [39:0] b);
    logic [39:0] o;
    logic        v;
    logic [8:0]  d;
    o = '0;
    v = 1'b0;
    for (int i = 0; i < 5; i++) begin
      d = {a[8*i+7], a[8*i +: 8]} - {b[8*i+7], b[8*i +: 8]};
      o[8*i +: 8] = d[7:0];
      v = v | (d[8] ^ d[7]);
    end
    return {v, o};
  endfunction

  logic [40:0] alu_res;
  always_comb alu_res = sub40(op_m1, op_m2);
  assign alu_out = alu_res[39:0];
  assign alu_ovf = alu_res[40];

  typedef struct {
    logic [39:0] a;
    logic [39:0] b;
    logic [39:0] c;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [39:0]   data;
  } sb_t;

  vec_t tbl [15];
  sb_t  sb_q [$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [39:0] sentinel(input int i);
    return 40'hA5A5A5A500 | 40'(i);
  endfunction

  task automatic load_rows(input int base);
    for (int i = 0; i < 16; i++) stage[i] = sentinel(i);
    for (int r = 0; r < 5; r++) begin
      stage[A_BASE + r] = tbl[base + r].a;
      stage[B_BASE + r] = tbl[base + r].b;
    end
    @(negedge clk) load = 1'b1;
    @(negedge clk) load = 1'b0;
  endtask

  function automatic logic [17:0] ctl_vec();
    return {busy, done, rd_en, rd_addr, wr_en, wr_addr, ovf_row, ovf_flag};
  endfunction

  task automatic run_table(input int base, input bit spurious, input int reset_at);
    int          k, r;
    bit          act, e_rd, e_wr, aborted;
    logic [AW-1:0] e_rda, e_wra;
    logic [4:0]  e_ovf;
    sb_t         got, want;

    for (int i = 0; i < 5; i++) begin
      want.addr = AW'(C_BASE + i);
      want.data = tbl[base + i].c;
      sb_q.push_back(want);
    end
    load_rows(base);
    aborted = 1'b0;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 28; c++) begin
      if (c > 1) begin
        @(posedge clk);
        #1;
      end
      start = spurious && (c == 3 || c == 26);
      if (c == reset_at) begin
        rst = 1'b0;
        #1;
        check("async_reset_ctl", 128'(ctl_vec()), 128'd0);
        check("async_reset_data", {8'd0, op_m1, op_m2, wr_data}, 128'd0);
        for (int j = 0; j < 3; j++) begin
          @(posedge clk);
          #1 check("reset_hold_ctl", 128'(ctl_vec()), 128'd0);
        end
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1 check("post_reset_idle", 128'(ctl_vec()), 128'd0);
        check("mem10_kept", 128'(mem[10]), 128'(tbl[base].c));
        check("mem11_kept", 128'(mem[11]), 128'(tbl[base + 1].c));
        check("mem12_untouched", 128'(mem[12]), 128'(sentinel(12)));
        sb_q.delete();
        aborted = 1'b1;
        break;
      end
      k     = (c - 1) % 5;
      r     = (c - 1) / 5;
      act   = (c <= 25);
      e_rd  = act && (k <= 1);
      e_rda = !e_rd ? '0 : (k == 0 ? AW'(A_BASE + r) : AW'(B_BASE + r));
      e_wr  = act && (k == 4);
      e_wra = e_wr ? AW'(C_BASE + r) : '0;
      for (int i = 0; i < 5; i++) e_ovf[i] = tbl[base + i].ovf && (c >= 5 + 5 * i);
      check($sformatf("ctl_c%0d", c), 128'(ctl_vec()),
            128'({act, c == 26, e_rd, e_rda, e_wr, e_wra, e_ovf, |e_ovf}));
      if (c == 1) check("ops_cleared", {8'd0, op_m1, op_m2, wr_data}, 128'd0);
      if (act && k == 2) check($sformatf("op_m1_r%0d", r), 128'(op_m1), 128'(tbl[base + r].a));
      if (act && k == 3) check($sformatf("ops_r%0d", r), 128'({op_m1, op_m2}),
                               128'({tbl[base + r].a, tbl[base + r].b}));
      if (wr_en) begin
        got.addr = wr_addr;
        got.data = wr_data;
        if (sb_q.size() == 0) begin
          check("sb_unexpected_write", 128'({got.addr, got.data}), 128'd0);
        end else begin
          want = sb_q.pop_front();
          check("sb_write", 128'({got.addr, got.data}), 128'({want.addr, want.data}));
          $display("[TB] write addr=%0d data=%h expected=%h", got.addr, got.data, want.data);
        end
      end
    end
    start = 1'b0;
    if (!aborted) begin
      check("sb_drained", 128'(sb_q.size()), 128'd0);
      for (int i = 0; i < 5; i++)
        check($sformatf("mem_c%0d", i), 128'(mem[C_BASE + i]), 128'(tbl[base + i].c));
    end
  endtask

  initial begin
    // Run 0: nominal subtract.
    tbl[0]  = '{40'h32281E140A, 40'h2D23190F05, 40'h0505050505, 1'b0};
    tbl[1]  = '{40'h0, 40'h0, 40'h0, 1'b0};
    tbl[2]  = '{40'h0, 40'h0, 40'h0, 1'b0};
    tbl[3]  = '{40'h0, 40'h0, 40'h0, 1'b0};
    tbl[4]  = '{40'h0, 40'h0, 40'h0, 1'b0};
    // Run 1: mixed signs in row 2, lane overflow in row 4.
    tbl[5]  = '{40'h0, 40'h0, 40'h0, 1'b0};
    tbl[6]  = '{40'h0, 40'h0, 40'h0, 1'b0};
    tbl[7]  = '{40'h32D81EEC0A, 40'hD323E70FFB, 40'h5FB537DD0F, 1'b0};
    tbl[8]  = '{40'h0, 40'h0, 40'h0, 1'b0};
    tbl[9]  = '{40'h32807F9C64, 40'h9CFF011E1E, 40'h96817E7E46, 1'b1};
    // Run 2: assorted lane patterns, overflow in rows 1 and 2.
    tbl[10] = '{40'h0102030405, 40'h0101010101, 40'h0001020304, 1'b0};
    tbl[11] = '{40'h7F00000000, 40'hFF00000000, 40'h8000000000, 1'b1};
    tbl[12] = '{40'h0000000080, 40'h0000000001, 40'h000000007F, 1'b1};
    tbl[13] = '{40'hFFFFFFFFFF, 40'h0101010101, 40'hFEFEFEFEFE, 1'b0};
    tbl[14] = '{40'h1122334455, 40'h1122334455, 40'h0000000000, 1'b0};

    rst   = 1'b0;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("reset_ctl", 128'(ctl_vec()), 128'd0);
    check("reset_data", {8'd0, op_m1, op_m2, wr_data}, 128'd0);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("start_in_reset_ignored", 128'(ctl_vec()), 128'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1 check("idle_after_release", 128'(ctl_vec()), 128'd0);

    $display("[TB] run nominal with spurious starts");
    run_table(0, 1'b1, 0);
    $display("[TB] run mixed/overflow");
    run_table(5, 1'b0, 0);
    repeat (3) @(posedge clk);
    #1 check("ovf_hold", 128'({ovf_row, ovf_flag, busy}), 128'({5'b10000, 1'b1, 1'b0}));
    $display("[TB] run assorted lanes");
    run_table(10, 1'b0, 0);
    $display("[TB] run with reset at cycle 12");
    run_table(0, 1'b0, 12);
    $display("[TB] run after reset");
    run_table(5, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
